mem_stage: RTL and testbench

// - Pipeline stage directly downstream of EX: performs data-memory load/store via req/ack handshake,

---
 rtl/dmem_if.sv | 21 ++
 rtl/mem_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the memory (slave).
interface dmem_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access with stall, branch resolution and MEM/WB registers.
// Optional access timeout with sticky fault flag is enabled by defining MEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no access outstanding; a new load/store may start (zero-wait if acked at once)
// WAIT  | request issued, waiting for dmem ack; upstream is stalled
module mem_stage #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int RADDR_W  = 4,
    parameter int ZERO_BIT = 0
`ifdef MEM_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               mem_write_enable,
    input  logic               mem_read_enable,
    input  logic [DATA_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic               is_branch,
    input  logic               sel_jflag_branch,
    input  logic               sel_beq_bne,
    input  logic               sel_jt_jf,
    input  logic [2:0]         jflag_cond,
    input  logic [5:0]         flags,
    input  logic [PC_W-1:0]    branch_addr,
    input  logic [1:0]         wb_res_mux,
    input  logic               reg_write_enable,
    input  logic [RADDR_W-1:0] reg_dest,
    input  logic [DATA_W-1:0]  alu_res,
    input  logic [DATA_W-1:0]  imm,
    input  logic [PC_W-1:0]    next_pc,
    dmem_if.master             dmem,
    output logic               stall_o,
    output logic               branch_taken_o,
    output logic [PC_W-1:0]    branch_target_o,
    output logic               mem_fault_o,
    output logic [1:0]         out_wb_res_mux,
    output logic               out_reg_write_enable,
    output logic [RADDR_W-1:0] out_reg_dest,
    output logic [DATA_W-1:0]  out_alu_res,
    output logic [DATA_W-1:0]  out_mem_rdata,
    output logic [DATA_W-1:0]  out_imm,
    output logic [PC_W-1:0]    out_next_pc
);

    typedef enum logic [0:0] {IDLE, WAIT} state_t;

    state_t state_q, state_d;

    logic start;
    logic timeout;
    logic req;
    logic load_ack;

    logic [1:0]         wb_res_mux_q, wb_res_mux_d;
    logic               reg_write_enable_q, reg_write_enable_d;
    logic [RADDR_W-1:0] reg_dest_q, reg_dest_d;
    logic [DATA_W-1:0]  alu_res_q, alu_res_d;
    logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [PC_W-1:0]    next_pc_q, next_pc_d;

    assign start = in_valid & (mem_read_enable | mem_write_enable) & (state_q == IDLE);

`ifdef MEM_TIMEOUT_EN
    logic [4:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;

    // Abort once TIMEOUT_CYCLES full WAIT cycles have passed without an ack.
    assign timeout = (state_q == WAIT) & ~dmem.ack & (cnt_q == 5'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d   = cnt_q;
        fault_d = fault_q | timeout;
        if (start & ~dmem.ack)
            cnt_d = '0;
        else if ((state_q == WAIT) & ~dmem.ack & ~timeout)
            cnt_d = cnt_q + 5'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign mem_fault_o = fault_q;
`else
    assign timeout     = 1'b0;
    assign mem_fault_o = 1'b0;
`endif

    assign req        = ~rst & (start | (state_q == WAIT)) & ~timeout;
    assign dmem.req   = req;
    assign dmem.we    = mem_write_enable;
    assign dmem.addr  = mem_addr;
    assign dmem.wdata = mem_data;
    assign stall_o    = req & ~dmem.ack;
    // Read and write both set is a store, so only a pure read captures rdata.
    assign load_ack   = req & dmem.ack & mem_read_enable & ~mem_write_enable;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start & ~dmem.ack) state_d = WAIT;
            WAIT:    if (dmem.ack | timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_res_mux_d       = wb_res_mux_q;
        reg_write_enable_d = 1'b0;
        reg_dest_d         = reg_dest_q;
        alu_res_d          = alu_res_q;
        mem_rdata_d        = mem_rdata_q;
        imm_d              = imm_q;
        next_pc_d          = next_pc_q;
        if (!stall_o) begin
            wb_res_mux_d       = wb_res_mux;
            reg_write_enable_d = reg_write_enable & in_valid & ~timeout;
            reg_dest_d         = reg_dest;
            alu_res_d          = alu_res;
            imm_d              = imm;
            next_pc_d          = next_pc;
            if (load_ack)
                mem_rdata_d = dmem.rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            wb_res_mux_q       <= '0;
            reg_write_enable_q <= 1'b0;
            reg_dest_q         <= '0;
            alu_res_q          <= '0;
            mem_rdata_q        <= '0;
            imm_q              <= '0;
            next_pc_q          <= '0;
        end else begin
            state_q            <= state_d;
            wb_res_mux_q       <= wb_res_mux_d;
            reg_write_enable_q <= reg_write_enable_d;
            reg_dest_q         <= reg_dest_d;
            alu_res_q          <= alu_res_d;
            mem_rdata_q        <= mem_rdata_d;
            imm_q              <= imm_d;
            next_pc_q          <= next_pc_d;
        end
    end

    assign out_wb_res_mux       = wb_res_mux_q;
    assign out_reg_write_enable = reg_write_enable_q;
    assign out_reg_dest         = reg_dest_q;
    assign out_alu_res          = alu_res_q;
    assign out_mem_rdata        = mem_rdata_q;
    assign out_imm              = imm_q;
    assign out_next_pc          = next_pc_q;

    logic [7:0] flags_ext;
    logic       zero_cond;
    logic       jflag_cond_ok;
    logic       br_cond;

    // Flag indices 6 and 7 do not exist; both jt and jf are then never taken.
    assign flags_ext     = {2'b00, flags};
    assign jflag_cond_ok = (jflag_cond < 3'd6);
    assign zero_cond     = sel_beq_bne ? flags[ZERO_BIT] : ~flags[ZERO_BIT];

    always_comb begin
        br_cond = zero_cond;
        if (sel_jflag_branch)
            br_cond = jflag_cond_ok & (sel_jt_jf ? flags_ext[jflag_cond] : ~flags_ext[jflag_cond]);
    end

    assign branch_taken_o  = ~rst & in_valid & is_branch & br_cond;
    assign branch_target_o = branch_addr;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: loads, stores, stalls, branches, reset and timeout.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_write_enable, mem_read_enable;
    logic [31:0] mem_addr, mem_data;
    logic        is_branch, sel_jflag_branch, sel_beq_bne, sel_jt_jf;
    logic [2:0]  jflag_cond;
    logic [5:0]  flags;
    logic [31:0] branch_addr;
    logic [1:0]  wb_res_mux;
    logic        reg_write_enable;
    logic [3:0]  reg_dest;
    logic [31:0] alu_res, imm, next_pc;
    logic        stall_o, branch_taken_o, mem_fault_o;
    logic [31:0] branch_target_o;
    logic [1:0]  out_wb_res_mux;
    logic        out_reg_write_enable;
    logic [3:0]  out_reg_dest;
    logic [31:0] out_alu_res, out_mem_rdata, out_imm, out_next_pc;

    int total = 0;
    int bad   = 0;

    dmem_if #(.DATA_W(32)) dmem ();

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_addr(mem_addr), .mem_data(mem_data), .is_branch(is_branch),
        .sel_jflag_branch(sel_jflag_branch), .sel_beq_bne(sel_beq_bne), .sel_jt_jf(sel_jt_jf),
        .jflag_cond(jflag_cond), .flags(flags), .branch_addr(branch_addr),
        .wb_res_mux(wb_res_mux), .reg_write_enable(reg_write_enable), .reg_dest(reg_dest),
        .alu_res(alu_res), .imm(imm), .next_pc(next_pc), .dmem(dmem.master),
        .stall_o(stall_o), .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o),
        .mem_fault_o(mem_fault_o), .out_wb_res_mux(out_wb_res_mux),
        .out_reg_write_enable(out_reg_write_enable), .out_reg_dest(out_reg_dest),
        .out_alu_res(out_alu_res), .out_mem_rdata(out_mem_rdata), .out_imm(out_imm),
        .out_next_pc(out_next_pc)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        in_valid = 0; mem_write_enable = 0; mem_read_enable = 0;
        mem_addr = 0; mem_data = 0; is_branch = 0; sel_jflag_branch = 0;
        sel_beq_bne = 0; sel_jt_jf = 0; jflag_cond = 0; flags = 0; branch_addr = 0;
        wb_res_mux = 0; reg_write_enable = 0; reg_dest = 0; alu_res = 0; imm = 0; next_pc = 0;
        dmem.ack = 0; dmem.rdata = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (dmem.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", dmem.req); end
        total++; if (out_reg_write_enable !== 1'b0) begin bad++; $display("FAIL reset_rwe got=%b exp=0", out_reg_write_enable); end
        total++; if (out_mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", out_mem_rdata); end
        total++; if (mem_fault_o !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", mem_fault_o); end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_load_zero_wait();
        @(negedge clk);
        in_valid = 1; mem_read_enable = 1; mem_addr = 32'h10; reg_dest = 4'd3;
        reg_write_enable = 1; wb_res_mux = 2'b01; alu_res = 32'h55; next_pc = 32'h204;
        dmem.ack = 1; dmem.rdata = 32'hDEADBEEF;
        #1;
        total++; if (dmem.req !== 1'b1 || dmem.we !== 1'b0) begin bad++; $display("FAIL load_req got=%b%b exp=10", dmem.req, dmem.we); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL load_stall got=%b exp=0", stall_o); end
        total++; if (dmem.addr !== 32'h10) begin bad++; $display("FAIL load_addr got=%h exp=10", dmem.addr); end
        @(posedge clk); #1;
        total++; if (out_mem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata got=%h exp=deadbeef", out_mem_rdata); end
        total++; if (out_reg_dest !== 4'd3 || out_reg_write_enable !== 1'b1) begin bad++; $display("FAIL load_wb got=%0d/%b exp=3/1", out_reg_dest, out_reg_write_enable); end
        total++; if (out_alu_res !== 32'h55 || out_wb_res_mux !== 2'b01 || out_next_pc !== 32'h204) begin bad++; $display("FAIL load_pass got=%h/%b/%h exp=55/01/204", out_alu_res, out_wb_res_mux, out_next_pc); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_store_wait();
        @(negedge clk);
        in_valid = 1; mem_write_enable = 1; mem_addr = 32'h40; mem_data = 32'h1234;
        reg_write_enable = 1; reg_dest = 4'd5; imm = 32'h77; dmem.rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            dmem.ack = (i == 3);
            #1;
            total++; if (dmem.req !== 1'b1 || dmem.we !== 1'b1) begin bad++; $display("FAIL store_req cyc=%0d got=%b%b exp=11", i, dmem.req, dmem.we); end
            total++; if (stall_o !== (i < 3)) begin bad++; $display("FAIL store_stall cyc=%0d got=%b exp=%b", i, stall_o, (i < 3)); end
            total++; if (dmem.addr !== 32'h40 || dmem.wdata !== 32'h1234) begin bad++; $display("FAIL store_bus got=%h/%h exp=40/1234", dmem.addr, dmem.wdata); end
            @(posedge clk); #1;
            total++; if (out_reg_write_enable !== (i == 3)) begin bad++; $display("FAIL store_wb cyc=%0d got=%b exp=%b", i, out_reg_write_enable, (i == 3)); end
        end
        total++; if (out_reg_dest !== 4'd5 || out_imm !== 32'h77) begin bad++; $display("FAIL store_fields got=%0d/%h exp=5/77", out_reg_dest, out_imm); end
        total++; if (out_mem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL store_rdata_hold got=%h exp=deadbeef", out_mem_rdata); end
        @(negedge clk); idle_inputs();
        #1;
        total++; if (dmem.req !== 1'b0) begin bad++; $display("FAIL store_idle_req got=%b exp=0", dmem.req); end
    endtask

    task automatic test_load_wait();
        @(negedge clk);
        in_valid = 1; mem_read_enable = 1; reg_write_enable = 1; reg_dest = 4'd9;
        dmem.rdata = 32'h11111111;
        @(posedge clk); #1;
        total++; if (out_mem_rdata !== 32'hDEADBEEF || out_reg_write_enable !== 1'b0) begin bad++; $display("FAIL ldw_bubble got=%h/%b exp=deadbeef/0", out_mem_rdata, out_reg_write_enable); end
        @(negedge clk); dmem.ack = 1; dmem.rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        total++; if (out_mem_rdata !== 32'hCAFEF00D || out_reg_dest !== 4'd9 || out_reg_write_enable !== 1'b1) begin bad++; $display("FAIL ldw_data got=%h/%0d/%b exp=cafef00d/9/1", out_mem_rdata, out_reg_dest, out_reg_write_enable); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_bubble_and_rw();
        // in_valid low with write-enable set plus a stray ack: no request, no WB write.
        @(negedge clk);
        reg_write_enable = 1; mem_read_enable = 1; dmem.ack = 1; dmem.rdata = 32'h22222222;
        #1;
        total++; if (dmem.req !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL bubble_req got=%b/%b exp=0/0", dmem.req, stall_o); end
        @(posedge clk); #1;
        total++; if (out_reg_write_enable !== 1'b0 || out_mem_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL bubble_wb got=%b/%h exp=0/cafef00d", out_reg_write_enable, out_mem_rdata); end
        @(negedge clk);
        in_valid = 1; mem_write_enable = 1; dmem.rdata = 32'h33333333;
        #1;
        total++; if (dmem.we !== 1'b1 || dmem.req !== 1'b1) begin bad++; $display("FAIL rw_we got=%b/%b exp=1/1", dmem.we, dmem.req); end
        @(posedge clk); #1;
        total++; if (out_mem_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL rw_rdata got=%h exp=cafef00d", out_mem_rdata); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_branch();
        // {in_valid,is_branch,sel_jflag,beq,jt,cond[2:0],flags[5:0],expected}
        logic [14:0] vec [13];
        vec[0]  = 15'b1_1_0_1_0_000_000001_1;
        vec[1]  = 15'b1_1_0_0_0_000_000001_0;
        vec[2]  = 15'b1_1_0_1_0_000_000000_0;
        vec[3]  = 15'b1_1_0_0_0_000_000000_1;
        vec[4]  = 15'b1_1_1_0_1_101_100000_1;
        vec[5]  = 15'b1_1_1_0_0_101_100000_0;
        vec[6]  = 15'b1_1_1_0_1_111_111111_0;
        vec[7]  = 15'b1_1_1_0_0_111_000000_0;
        vec[8]  = 15'b1_1_1_0_0_110_000000_0;
        vec[9]  = 15'b1_1_1_0_1_010_000100_1;
        vec[10] = 15'b1_1_1_0_0_010_000000_1;
        vec[11] = 15'b0_1_0_1_0_000_000001_0;
        vec[12] = 15'b1_0_0_1_0_000_000001_0;
        @(negedge clk);
        branch_addr = 32'h100;
        for (int i = 0; i < 13; i++) begin
            in_valid = vec[i][14]; is_branch = vec[i][13]; sel_jflag_branch = vec[i][12];
            sel_beq_bne = vec[i][11]; sel_jt_jf = vec[i][10]; jflag_cond = vec[i][9:7];
            flags = vec[i][6:1];
            #1;
            total++; if (branch_taken_o !== vec[i][0]) begin bad++; $display("FAIL branch vec=%0d got=%b exp=%b", i, branch_taken_o, vec[i][0]); end
            total++; if (branch_target_o !== 32'h100) begin bad++; $display("FAIL branch_target vec=%0d got=%h exp=100", i, branch_target_o); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        in_valid = 1; mem_read_enable = 1; reg_write_enable = 1; reg_dest = 4'd7;
        is_branch = 1; sel_beq_bne = 1; flags = 6'b000001;
        @(posedge clk); #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL rstw_stall got=%b exp=1", stall_o); end
        @(negedge clk); rst = 1;
        #1;
        total++; if (dmem.req !== 1'b0 || stall_o !== 1'b0 || branch_taken_o !== 1'b0) begin bad++; $display("FAIL rstw_comb got=%b/%b/%b exp=0/0/0", dmem.req, stall_o, branch_taken_o); end
        @(posedge clk); #1;
        total++; if (out_mem_rdata !== 32'h0 || out_reg_dest !== 4'd0 || out_reg_write_enable !== 1'b0) begin bad++; $display("FAIL rstw_regs got=%h/%0d/%b exp=0/0/0", out_mem_rdata, out_reg_dest, out_reg_write_enable); end
        @(negedge clk); rst = 0; idle_inputs();
        #1;
        total++; if (dmem.req !== 1'b0) begin bad++; $display("FAIL rstw_idle got=%b exp=0", dmem.req); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        in_valid = 1; mem_read_enable = 1; reg_write_enable = 1;
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 17; i++) begin
            #1;
            total++; if (dmem.req !== 1'b1) begin bad++; $display("FAIL to_req cyc=%0d got=%b exp=1", i, dmem.req); end
            @(negedge clk);
        end
        #1;
        total++; if (dmem.req !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL to_abort got=%b/%b exp=0/0", dmem.req, stall_o); end
        @(posedge clk); #1;
        total++; if (mem_fault_o !== 1'b1 || out_reg_write_enable !== 1'b0) begin bad++; $display("FAIL to_fault got=%b/%b exp=1/0", mem_fault_o, out_reg_write_enable); end
        @(negedge clk); idle_inputs(); dmem.ack = 1;
        repeat (3) @(posedge clk); #1;
        total++; if (mem_fault_o !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", mem_fault_o); end
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        total++; if (mem_fault_o !== 1'b0) begin bad++; $display("FAIL to_rst got=%b exp=0", mem_fault_o); end
        @(negedge clk); rst = 0; idle_inputs();
`else
        for (int i = 0; i < 25; i++) begin
            #1;
            total++; if (stall_o !== 1'b1 || mem_fault_o !== 1'b0) begin bad++; $display("FAIL nto_wait cyc=%0d got=%b/%b exp=1/0", i, stall_o, mem_fault_o); end
            @(negedge clk);
        end
        dmem.ack = 1;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL nto_ack got=%b exp=0", stall_o); end
        @(negedge clk); idle_inputs();
`endif
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_load_zero_wait();
        test_store_wait();
        test_load_wait();
        test_bubble_and_rw();
        test_branch();
        test_reset_in_wait();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
